mix_columns_seq: RTL and testbench

- Sequencer that runs a multi-word cipher state through the shared 16-bit MixColumns datapath unit (mix_columns_16), one 16-bit word per cycle, fully pipelined.
- Accepts a full state over a valid/ready handshake, streams its words into the datapath, collects the results in order, and presents the transformed state over a second valid/ready handshake.
- Sits between the round controller of the cryptographic core and the single MixColumns instance.

---
 rtl/mix_columns_seq.sv | 105 ++++++++++
 tb/tb_mix_columns_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// Streams a NUM_WORDS x 16-bit cipher state through the shared mix_columns_16
// datapath one word per cycle and reassembles the results in order.
module mix_columns_seq #(
  parameter int NUM_WORDS  = 4,
  parameter int DP_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [16*NUM_WORDS-1:0]   in_state,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [16*NUM_WORDS-1:0]   out_state,
  output logic [15:0]               mc_data_in,
  input  logic [15:0]               mc_data_out,
  output logic                      busy,
  output logic [15:0]               blocks_done
);

  localparam int SW = 16*NUM_WORDS;
  localparam int CW = $clog2(NUM_WORDS+1);
  localparam logic [CW-1:0] NW_C   = CW'(NUM_WORDS);
  localparam logic [CW-1:0] LAST_C = CW'(NUM_WORDS-1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]       src;
  logic [SW-17:0]      res;
  logic [SW-1:0]       res_nxt;
  logic [CW-1:0]       issue_cnt, cap_cnt;
  logic [DP_LATENCY:0] pipe_vld;
  logic                accept, issue_more, cap, cap_last, out_hs;

  assign in_ready   = (state == IDLE);
  assign busy       = (state == RUN) || (state == DONE);
  assign accept     = in_valid && in_ready;
  assign issue_more = (state == RUN) && (issue_cnt < NW_C);
  assign cap        = (state == RUN) && pipe_vld[DP_LATENCY];
  assign cap_last   = cap && (cap_cnt == LAST_C);
  assign out_hs     = out_valid && out_ready;
  // Results enter at the bottom so word 0 ends up most significant.
  assign res_nxt    = {res, mc_data_out};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (cap_last) state_nxt = DONE;
      DONE:    if (out_hs)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      src         <= '0;
      res         <= '0;
      out_state   <= '0;
      out_valid   <= 1'b0;
      mc_data_in  <= '0;
      blocks_done <= '0;
      issue_cnt   <= '0;
      cap_cnt     <= '0;
      pipe_vld    <= '0;
    end else begin
      // Tail of pipe_vld marks the cycle a datapath result is valid.
      pipe_vld <= {pipe_vld[DP_LATENCY-1:0], accept || issue_more};

      // Source buffer shifts left so the next word is always on top.
      if (accept) begin
        mc_data_in <= in_state[SW-1 -: 16];
        src        <= in_state << 16;
        issue_cnt  <= CW'(1);
        cap_cnt    <= '0;
      end else if (issue_more) begin
        mc_data_in <= src[SW-1 -: 16];
        src        <= src << 16;
        issue_cnt  <= issue_cnt + CW'(1);
      end

      if (cap) begin
        res     <= res_nxt[SW-17:0];
        cap_cnt <= cap_cnt + CW'(1);
        if (cap_last) begin
          out_state <= res_nxt;
          out_valid <= 1'b1;
        end
      end

      if (out_hs) begin
        out_valid   <= 1'b0;
        blocks_done <= blocks_done + 16'd1;
        mc_data_in  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Randomised bench for mix_columns_seq: a cycle-level reference model of the
// block protocol plus fixed vectors, with a second instance at DP_LATENCY=3.
module tb_mix_columns_seq;

  localparam int NW = 4;
  localparam int DL = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] in_state, out_state;
  logic [15:0] mc_in, mc_out, blocks_done;

  logic        in1_valid, in1_ready, out1_valid, busy1;
  logic [63:0] in1_state, out1_state;
  logic [15:0] mc1_in, mc1_out, blocks1, d1, d2, d3;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  mix_columns_seq #(.NUM_WORDS(NW), .DP_LATENCY(DL)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .mc_data_in(mc_in), .mc_data_out(mc_out),
    .busy(busy), .blocks_done(blocks_done)
  );

  mix_columns_seq #(.NUM_WORDS(4), .DP_LATENCY(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready),
    .in_state(in1_state), .out_valid(out1_valid), .out_ready(1'b1),
    .out_state(out1_state), .mc_data_in(mc1_in), .mc_data_out(mc1_out),
    .busy(busy1), .blocks_done(blocks1)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Two-byte MixColumns: [2 3; 3 2] over GF(2^8).
  function automatic logic [15:0] mix16(input logic [15:0] w);
    logic [7:0] a, b;
    a = w[15:8];
    b = w[7:0];
    return {xt(a) ^ xt(b) ^ b, xt(a) ^ a ^ xt(b)};
  endfunction

  function automatic logic [15:0] word_of(input logic [63:0] s, input int i);
    return s[63-16*i -: 16];
  endfunction

  function automatic logic [63:0] mix_state(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r[63-16*i -: 16] = mix16(word_of(s, i));
    return r;
  endfunction

  // Datapath stand-ins: real transform with latency 1, identity with latency 3.
  always_ff @(posedge clk) begin
    if (!rst) mc_out <= '0;
    else      mc_out <= mix16(mc_in);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      d1 <= '0; d2 <= '0; d3 <= '0;
    end else begin
      d1 <= mc1_in; d2 <= d1; d3 <= d2;
    end
  end
  assign mc1_out = d3;

  // Reference model of u0: phase 0 idle, 1 running, 2 result waiting.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic        m_valid = 1'b0;
  logic [63:0] m_src = '0, m_out = '0;
  logic [15:0] m_blocks = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_phase = 0; m_cnt = 0; m_valid = 1'b0; m_out = '0; m_blocks = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin m_src = in_state; m_cnt = 0; m_phase = 1; end
        1: begin
          m_cnt++;
          if (m_cnt == NW + DL) begin
            m_valid = 1'b1; m_out = mix_state(m_src); m_phase = 2;
          end
        end
        default: if (out_ready) begin
          m_valid = 1'b0; m_blocks = m_blocks + 16'd1; m_phase = 0;
        end
      endcase
    end
  end

  function automatic logic [15:0] exp_mc();
    if (m_phase == 0) return 16'h0000;
    return word_of(m_src, (m_cnt < NW) ? m_cnt : NW - 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",    in_ready,    m_phase == 0);
      chk("busy",        busy,        m_phase != 0);
      chk("out_valid",   out_valid,   m_valid);
      chk("out_state",   out_state,   m_out);
      chk("blocks_done", blocks_done, m_blocks);
      chk("mc_data_in",  mc_in,       exp_mc());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [63:0] s;
    in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
    in1_valid = 1'b0; in1_state = '0;
    rst = 1'b0;
    step(1);
    chk_en = 1'b1;
    step(2);
    rst = 1'b1;

    // Reset two edges into a block aborts it.
    in_state = {$urandom, $urandom}; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_blocks", blocks_done, 16'd0);
    step(8);

    // Basic transform and latency.
    in_state = 64'h0101_8000_D4BF_0000; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(4);
    chk("lat_early", out_valid, 1'b0);
    step(1);
    chk("lat5_valid", out_valid, 1'b1);
    chk("basic_state", out_state, 64'h0101_1B9B_6902_0000);
    step(1);
    chk("basic_blocks", blocks_done, 16'd1);
    chk("basic_idle", in_ready, 1'b1);

    // Backpressure holds the result.
    out_ready = 1'b0;
    in_state = {$urandom, $urandom}; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(5);
    chk("bp_valid", out_valid, 1'b1);
    step(10);
    chk("bp_hold", out_valid, 1'b1);
    out_ready = 1'b1;
    step(1);
    chk("bp_release", out_valid, 1'b0);
    chk("bp_ready", in_ready, 1'b1);

    // Back-to-back with in_valid held high.
    in_state = {$urandom, $urandom}; in_valid = 1'b1;
    step(1);
    in_state = 64'h8000_8000_8000_8000;
    step(6);
    chk("b2b_gap_ready", in_ready, 1'b1);
    step(1);
    chk("b2b_second_accept", in_ready, 1'b0);
    in_valid = 1'b0;
    step(5);
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_state", out_state, 64'h1B9B_1B9B_1B9B_1B9B);
    step(1);

    // Random traffic with occasional resets.
    repeat (400) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_state  = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 60) != 0);
      step(1);
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(12);

    // Counter wrap.
    force u0.blocks_done = 16'hFFFF;
    m_blocks = 16'hFFFF;
    #1;
    release u0.blocks_done;
    in_state = {$urandom, $urandom}; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(5);
    chk("wrap_valid", out_valid, 1'b1);
    step(1);
    chk("wrap_blocks", blocks_done, 16'h0000);

    // Deeper datapath: identity stub, DP_LATENCY=3.
    for (int k = 0; k < 6; k++) begin
      s = (k == 0) ? 64'h1111_2222_3333_4444 : {$urandom, $urandom};
      chk("lat3_ready", in1_ready, 1'b1);
      in1_state = s; in1_valid = 1'b1;
      step(1);
      in1_valid = 1'b0;
      in1_state = {$urandom, $urandom};
      chk("lat3_busy", busy1, 1'b1);
      step(6);
      chk("lat3_early", out1_valid, 1'b0);
      step(1);
      chk("lat3_valid", out1_valid, 1'b1);
      chk("lat3_state", out1_state, s);
      step(1);
    end
    chk("lat3_blocks", blocks1, 16'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
